// File: rtl/output_vc_ctrl.sv
// output_vc_ctrl
//   Output-port controller for one router direction. Holds one packet buffer per
//   virtual channel (even/odd), accepts writes from the even and odd arbitrators
//   and shares the single output link between the two VCs by router polarity.
//
//   polarity=0: even VC internal (writable), odd VC external (sendable).
//   polarity=1: odd VC internal, even VC external.
//
// Ports
//   clk           router clock, rising edge
//   reset         asynchronous active-low reset
//   polarity      router phase, toggles every cycle
//   even_wr_en    even arbitrator write enable
//   even_wr_data  even arbitrator write data
//   odd_wr_en     odd arbitrator write enable
//   odd_wr_data   odd arbitrator write data
//   even_empty    even buffer empty (to even arbitrator)
//   odd_empty     odd buffer empty (to odd arbitrator)
//   out_ready     downstream input buffer for the external VC is empty
//   out_send      link valid, one cycle per transmitted packet
//   out_data      link data, holds last value when idle
//   pkt_count     packets transmitted since reset, wraps
//   err_overflow  sticky: write hit a full buffer
//   err_phase     sticky: write targeted the external VC
module output_vc_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  even_wr_en,
    input  logic [DATA_WIDTH-1:0] even_wr_data,
    input  logic                  odd_wr_en,
    input  logic [DATA_WIDTH-1:0] odd_wr_data,
    output logic                  even_empty,
    output logic                  odd_empty,
    input  logic                  out_ready,
    output logic                  out_send,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  err_overflow,
    output logic                  err_phase
);

    logic                  even_full_q, even_full_d;
    logic                  odd_full_q, odd_full_d;
    logic [DATA_WIDTH-1:0] buf_even_q, buf_even_d;
    logic [DATA_WIDTH-1:0] buf_odd_q, buf_odd_d;
    logic                  out_send_q, out_send_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  err_phase_q, err_phase_d;

    logic even_wr_ok, odd_wr_ok;
    logic overflow_hit, phase_hit;
    logic ext_full, send;
    logic [DATA_WIDTH-1:0] ext_data;

    always_comb begin
        // Writes are only legal to the internal VC of this phase.
        even_wr_ok   = even_wr_en & ~polarity & ~even_full_q;
        odd_wr_ok    = odd_wr_en  &  polarity & ~odd_full_q;
        overflow_hit = (even_wr_en & ~polarity & even_full_q) |
                       (odd_wr_en  &  polarity & odd_full_q);
        phase_hit    = (even_wr_en & polarity) | (odd_wr_en & ~polarity);

        ext_full = polarity ? even_full_q : odd_full_q;
        ext_data = polarity ? buf_even_q  : buf_odd_q;
        send     = ext_full & out_ready;
    end

    always_comb begin
        even_full_d    = even_full_q;
        odd_full_d     = odd_full_q;
        buf_even_d     = buf_even_q;
        buf_odd_d      = buf_odd_q;
        out_send_d     = send;
        out_data_d     = out_data_q;
        pkt_count_d    = pkt_count_q;
        err_overflow_d = err_overflow_q | overflow_hit;
        err_phase_d    = err_phase_q | phase_hit;

        if (even_wr_ok) begin
            buf_even_d  = even_wr_data;
            even_full_d = 1'b1;
        end
        if (odd_wr_ok) begin
            buf_odd_d  = odd_wr_data;
            odd_full_d = 1'b1;
        end

        // Write and send always touch different VCs, so no priority is needed.
        if (send) begin
            out_data_d  = ext_data;
            pkt_count_d = pkt_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (polarity) begin
                even_full_d = 1'b0;
            end else begin
                odd_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            even_full_q    <= 1'b0;
            odd_full_q     <= 1'b0;
            buf_even_q     <= '0;
            buf_odd_q      <= '0;
            out_send_q     <= 1'b0;
            out_data_q     <= '0;
            pkt_count_q    <= '0;
            err_overflow_q <= 1'b0;
            err_phase_q    <= 1'b0;
        end else begin
            even_full_q    <= even_full_d;
            odd_full_q     <= odd_full_d;
            buf_even_q     <= buf_even_d;
            buf_odd_q      <= buf_odd_d;
            out_send_q     <= out_send_d;
            out_data_q     <= out_data_d;
            pkt_count_q    <= pkt_count_d;
            err_overflow_q <= err_overflow_d;
            err_phase_q    <= err_phase_d;
        end
    end

    assign even_empty   = ~even_full_q;
    assign odd_empty    = ~odd_full_q;
    assign out_send     = out_send_q;
    assign out_data     = out_data_q;
    assign pkt_count    = pkt_count_q;
    assign err_overflow = err_overflow_q;
    assign err_phase    = err_phase_q;

endmodule

// File: tb/tb_output_vc_ctrl.sv
module tb_output_vc_ctrl;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          polarity = 1'b0;
    logic          even_wr_en = 1'b0;
    logic [DW-1:0] even_wr_data = '0;
    logic          odd_wr_en = 1'b0;
    logic [DW-1:0] odd_wr_data = '0;
    logic          even_empty, odd_empty;
    logic          out_ready = 1'b0;
    logic          out_send;
    logic [DW-1:0] out_data;
    logic [CW-1:0] pkt_count;
    logic          err_overflow, err_phase;

    output_vc_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .polarity     (polarity),
        .even_wr_en   (even_wr_en),
        .even_wr_data (even_wr_data),
        .odd_wr_en    (odd_wr_en),
        .odd_wr_data  (odd_wr_data),
        .even_empty   (even_empty),
        .odd_empty    (odd_empty),
        .out_ready    (out_ready),
        .out_send     (out_send),
        .out_data     (out_data),
        .pkt_count    (pkt_count),
        .err_overflow (err_overflow),
        .err_phase    (err_phase)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: one slot per VC, index 0 = even, 1 = odd.
    logic          m_full [2];
    logic [DW-1:0] m_buf  [2];
    logic          m_send;
    logic [DW-1:0] m_data;
    int unsigned   m_cnt;
    logic          m_ovf, m_phs;
    logic          pol;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            m_full[v] = 1'b0;
            m_buf[v]  = '0;
        end
        m_send = 1'b0;
        m_data = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_phs  = 1'b0;
    endtask

    task automatic model_step(input logic ee, input logic [DW-1:0] ed, input logic oe,
                              input logic [DW-1:0] od, input logic rdy);
        logic          en [2];
        logic [DW-1:0] dat [2];
        int            ext;
        en[0] = ee; en[1] = oe;
        dat[0] = ed; dat[1] = od;
        ext = pol ? 0 : 1;
        for (int v = 0; v < 2; v++) begin
            if (en[v]) begin
                if (v == ext)        m_phs = 1'b1;
                else if (m_full[v])  m_ovf = 1'b1;
                else begin
                    m_buf[v]  = dat[v];
                    m_full[v] = 1'b1;
                end
            end
        end
        if (m_full[ext] && rdy) begin
            m_send      = 1'b1;
            m_data      = m_buf[ext];
            m_full[ext] = 1'b0;
            m_cnt       = (m_cnt + 1) % (1 << CW);
        end else begin
            m_send = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("out_send",     64'(out_send),     64'(m_send));
        check_eq("out_data",     out_data,          m_data);
        check_eq("pkt_count",    64'(pkt_count),    64'(m_cnt));
        check_eq("even_empty",   64'(even_empty),   64'(!m_full[0]));
        check_eq("odd_empty",    64'(odd_empty),    64'(!m_full[1]));
        check_eq("err_overflow", 64'(err_overflow), 64'(m_ovf));
        check_eq("err_phase",    64'(err_phase),    64'(m_phs));
    endtask

    // Called at posedge+1; drives one cycle of inputs and checks after the edge.
    task automatic cycle(input logic ee, input logic [DW-1:0] ed, input logic oe,
                         input logic [DW-1:0] od, input logic rdy);
        polarity     = pol;
        even_wr_en   = ee;
        even_wr_data = ed;
        odd_wr_en    = oe;
        odd_wr_data  = od;
        out_ready    = rdy;
        model_step(ee, ed, oe, od, rdy);
        @(posedge clk);
        #1;
        pol = ~pol;
        compare_all();
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic align(input logic p);
        if (pol != p) idle(1'b0);
    endtask

    // Assert reset between edges, check the asynchronous effect, release after one edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        pol        = 1'b0;
        even_wr_en = 1'b0;
        odd_wr_en  = 1'b0;
    endtask

    localparam logic [DW-1:0] DataAa = 64'h0012_3400_0000_00AA;
    localparam logic [DW-1:0] DataBb = 64'h0012_3400_0000_00BB;
    localparam logic [DW-1:0] DataOd = 64'h8056_7800_0000_00CC;

    initial begin
        int pulses;
        logic [DW-1:0] seen;
        logic ee, oe, rdy;
        pol = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_even_empty", 64'(even_empty), 64'd1);
        check_eq("rst_pkt_count",  64'(pkt_count),  64'd0);

        // Reset mid-operation with a packet waiting in the even buffer.
        align(1'b0);
        cycle(1'b1, DataAa, 1'b0, '0, 1'b0);
        check_eq("fill_even_empty", 64'(even_empty), 64'd0);
        do_reset();
        check_eq("midrst_even_empty", 64'(even_empty), 64'd1);
        check_eq("midrst_out_send",   64'(out_send),   64'd0);
        check_eq("midrst_pkt_count",  64'(pkt_count),  64'd0);

        // Basic path.
        align(1'b0);
        cycle(1'b1, DataAa, 1'b0, '0, 1'b1);
        check_eq("basic_even_empty0", 64'(even_empty), 64'd0);
        idle(1'b1);
        check_eq("basic_send",        64'(out_send),   64'd1);
        check_eq("basic_data",        out_data,        DataAa);
        check_eq("basic_cnt",         64'(pkt_count),  64'd1);
        check_eq("basic_even_empty1", 64'(even_empty), 64'd1);

        // Backpressure on the odd VC for three external phases.
        align(1'b1);
        cycle(1'b0, '0, 1'b1, DataOd, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle(1'b0);
            check_eq("bp_no_send",   64'(out_send),  64'd0);
            check_eq("bp_odd_full",  64'(odd_empty), 64'd0);
        end
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (out_send) begin
                pulses++;
                seen = out_data;
            end
        end
        check_eq("bp_pulses", 64'(pulses), 64'd1);
        check_eq("bp_data",   seen,        DataOd);

        // Overflow keeps the original contents.
        align(1'b0);
        cycle(1'b1, DataAa, 1'b0, '0, 1'b0);
        idle(1'b0);
        cycle(1'b1, DataBb, 1'b0, '0, 1'b0);
        check_eq("ovf_flag", 64'(err_overflow), 64'd1);
        idle(1'b1);
        check_eq("ovf_send", 64'(out_send), 64'd1);
        check_eq("ovf_data", out_data,      DataAa);

        // Phase error: odd write while odd is external.
        align(1'b0);
        cycle(1'b0, '0, 1'b1, DataOd, 1'b0);
        check_eq("phs_flag",      64'(err_phase), 64'd1);
        check_eq("phs_odd_empty", 64'(odd_empty), 64'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ee  = ($urandom % 4) != 0;
            oe  = ($urandom % 4) != 0;
            rdy = ($urandom % 3) != 0;
            cycle(ee, {$urandom, $urandom}, oe, {$urandom, $urandom}, rdy);
        end

        // Sustained traffic: write the internal VC every cycle, link always ready.
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            if (pol) cycle(1'b0, '0, 1'b1, {1'b1, 31'(i), 32'(~i)}, 1'b1);
            else     cycle(1'b1, {1'b0, 31'(i), 32'(~i)}, 1'b0, '0, 1'b1);
        end
        check_eq("wrap_cnt",      64'(pkt_count),    64'd3);
        check_eq("wrap_no_ovf",   64'(err_overflow), 64'd0);
        check_eq("wrap_no_phase", 64'(err_phase),    64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
